// File: rtl/membus_pkg.sv
// Shared memory-bus definitions: scheduler state, owner encoding, write-tag bit.
package membus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_WDATA = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } owner_e;

   // The tag MSB flags a write transaction.
   function automatic int write_bit(input int tag_width);
      return tag_width - 1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; bit 0 is the I-side, bit 1 the D-side.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_d,
   output logic [1:0] gnt
);

   assign gnt[0] = req[0] & (~req[1] | last_d);
   assign gnt[1] = req[1] & (~req[0] | ~last_d);

endmodule

// File: rtl/membus_scheduler.sv
// Shares one system bus between fetcher and data memory, one line transfer at a time.
module membus_scheduler
   import membus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int LINE_BEATS     = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ibus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
   output logic                      ibus_reqack,
   output logic                      ibus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,
   input  logic                      ibus_respack,
   input  logic                      dbus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
   output logic                      dbus_reqack,
   output logic                      dbus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,
   input  logic                      dbus_respack,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      bus_respack,
   output logic [1:0]                owner
);

   localparam int CW = $clog2(LINE_BEATS) + 1;
   localparam int WB = write_bit(BUS_TAG_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic            last_d_q, last_d_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      gnt;

   logic                      sel_cyc;
   logic [BUS_DATA_WIDTH-1:0] sel_req;
   logic [BUS_TAG_WIDTH-1:0]  sel_tag;
   logic                      sel_respack;
   logic                      hit_i, hit_d, act_req, act_resp;

   rr_arb2 u_arb (
      .req    ({dbus_reqcyc, ibus_reqcyc}),
      .last_d (last_d_q),
      .gnt    (gnt)
   );

   assign hit_i    = (owner_q == OWN_I);
   assign hit_d    = (owner_q == OWN_D);
   assign act_req  = !reset && (state_q == ST_ADDR || state_q == ST_WDATA);
   assign act_resp = !reset && (state_q == ST_RESP);

   always_comb begin
      sel_cyc     = 1'b0;
      sel_req     = '0;
      sel_tag     = '0;
      sel_respack = 1'b0;
      if (hit_i) begin
         sel_cyc     = ibus_reqcyc;
         sel_req     = ibus_req;
         sel_tag     = ibus_reqtag;
         sel_respack = ibus_respack;
      end else if (hit_d) begin
         sel_cyc     = dbus_reqcyc;
         sel_req     = dbus_req;
         sel_tag     = dbus_reqtag;
         sel_respack = dbus_respack;
      end
   end

   assign bus_reqcyc   = act_req & sel_cyc;
   assign bus_req      = act_req ? sel_req : '0;
   assign bus_reqtag   = act_req ? sel_tag : '0;
   assign ibus_reqack  = act_req & hit_i & bus_reqack;
   assign dbus_reqack  = act_req & hit_d & bus_reqack;

   assign ibus_respcyc = act_resp & hit_i & bus_respcyc;
   assign ibus_resp    = (act_resp && hit_i) ? bus_resp : '0;
   assign ibus_resptag = (act_resp && hit_i) ? bus_resptag : '0;
   assign dbus_respcyc = act_resp & hit_d & bus_respcyc;
   assign dbus_resp    = (act_resp && hit_d) ? bus_resp : '0;
   assign dbus_resptag = (act_resp && hit_d) ? bus_resptag : '0;
   assign bus_respack  = act_resp & sel_respack;

   assign owner = reset ? 2'b00 : owner_q;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d_d = last_d_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               state_d  = ST_ADDR;
               owner_d  = gnt[0] ? OWN_I : OWN_D;
               last_d_d = gnt[1];
               cnt_d    = '0;
            end
         end
         ST_ADDR: begin
            if (!sel_cyc) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
            end else if (bus_reqack) begin
               state_d = sel_tag[WB] ? ST_WDATA : ST_RESP;
               cnt_d   = '0;
            end
         end
         ST_WDATA: begin
            if (!sel_cyc) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
            end else if (bus_reqack) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d = ST_IDLE;
                  owner_d = OWN_NONE;
                  cnt_d   = '0;
               end
            end
         end
         ST_RESP: begin
            if (bus_respcyc && sel_respack) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d = ST_IDLE;
                  owner_d = OWN_NONE;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Last-grant starts on the D-side so the first tie goes to the fetcher.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_NONE;
         last_d_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_d_q <= last_d_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_membus_scheduler.sv
// Directed and randomized transactions against a transaction-level model of the scheduler.
module tb_membus_scheduler;

   localparam int DW = 64;
   localparam int TW = 13;
   localparam int LB = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          ibus_reqcyc, ibus_reqack, ibus_respcyc, ibus_respack;
   logic [DW-1:0] ibus_req, ibus_resp;
   logic [TW-1:0] ibus_reqtag, ibus_resptag;
   logic          dbus_reqcyc, dbus_reqack, dbus_respcyc, dbus_respack;
   logic [DW-1:0] dbus_req, dbus_resp;
   logic [TW-1:0] dbus_reqtag, dbus_resptag;
   logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
   logic [DW-1:0] bus_req, bus_resp;
   logic [TW-1:0] bus_reqtag, bus_resptag;
   logic [1:0]    owner;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] addr_m [2];
   logic [TW-1:0] tag_m [2];
   bit            pend [2];
   int            last_tb;

   membus_scheduler #(
      .BUS_DATA_WIDTH (DW),
      .BUS_TAG_WIDTH  (TW),
      .LINE_BEATS     (LB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ibus_reqcyc  (ibus_reqcyc),
      .ibus_req     (ibus_req),
      .ibus_reqtag  (ibus_reqtag),
      .ibus_reqack  (ibus_reqack),
      .ibus_respcyc (ibus_respcyc),
      .ibus_resp    (ibus_resp),
      .ibus_resptag (ibus_resptag),
      .ibus_respack (ibus_respack),
      .dbus_reqcyc  (dbus_reqcyc),
      .dbus_req     (dbus_req),
      .dbus_reqtag  (dbus_reqtag),
      .dbus_reqack  (dbus_reqack),
      .dbus_respcyc (dbus_respcyc),
      .dbus_resp    (dbus_resp),
      .dbus_resptag (dbus_resptag),
      .dbus_respack (dbus_respack),
      .bus_reqcyc   (bus_reqcyc),
      .bus_req      (bus_req),
      .bus_reqtag   (bus_reqtag),
      .bus_reqack   (bus_reqack),
      .bus_respcyc  (bus_respcyc),
      .bus_resp     (bus_resp),
      .bus_resptag  (bus_resptag),
      .bus_respack  (bus_respack),
      .owner        (owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic ack_of(input int s);
      return (s == 0) ? ibus_reqack : dbus_reqack;
   endfunction

   function automatic logic respcyc_of(input int s);
      return (s == 0) ? ibus_respcyc : dbus_respcyc;
   endfunction

   function automatic logic [DW-1:0] resp_of(input int s);
      return (s == 0) ? ibus_resp : dbus_resp;
   endfunction

   function automatic logic [TW-1:0] resptag_of(input int s);
      return (s == 0) ? ibus_resptag : dbus_resptag;
   endfunction

   task automatic set_side(input int s, input logic cyc, input logic [DW-1:0] d, input logic [TW-1:0] t);
      if (s == 0) begin
         ibus_reqcyc = cyc; ibus_req = d; ibus_reqtag = t;
      end else begin
         dbus_reqcyc = cyc; dbus_req = d; dbus_reqtag = t;
      end
   endtask

   task automatic set_respack(input int s, input logic v);
      if (s == 0) ibus_respack = v;
      else dbus_respack = v;
   endtask

   task automatic clear_all();
      ibus_reqcyc = 0; ibus_req = '0; ibus_reqtag = '0; ibus_respack = 0;
      dbus_reqcyc = 0; dbus_req = '0; dbus_reqtag = '0; dbus_respack = 0;
      bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
   endtask

   task automatic post(input int s, input bit wr);
      addr_m[s] = {$urandom, $urandom};
      tag_m[s]  = {wr, 12'($urandom)};
      set_side(s, 1'b1, addr_m[s], tag_m[s]);
      pend[s] = 1;
   endtask

   // Round robin: on a tie the side not granted last wins.
   function automatic int pick();
      int w;
      if (pend[0] && pend[1]) w = (last_tb == 1) ? 0 : 1;
      else w = pend[0] ? 0 : 1;
      last_tb = w;
      pend[w] = 0;
      return w;
   endfunction

   task automatic serve(input int s, input int rst_beat);
      logic [1:0]    own;
      int            o, w;
      logic          hs;
      logic [DW-1:0] d;
      logic [TW-1:0] t;
      own = (s == 0) ? 2'b01 : 2'b10;
      o = 1 - s;
      #1;
      chk("idle_owner", owner, 2'b00);
      chk("idle_buscyc", bus_reqcyc, 1'b0);
      chk("idle_iack", ibus_reqack, 1'b0);
      chk("idle_dack", dbus_reqack, 1'b0);
      adv();
      w = $urandom_range(0, 2);
      for (int k = 0; k <= w; k++) begin
         bus_reqack = (k == w);
         #1;
         chk("addr_owner", owner, own);
         chk("addr_cyc", bus_reqcyc, 1'b1);
         chk("addr_req", bus_req, addr_m[s]);
         chk("addr_tag", bus_reqtag, tag_m[s]);
         chk("addr_ack", ack_of(s), k == w);
         chk("addr_other_ack", ack_of(o), 1'b0);
         adv();
      end
      bus_reqack = 0;
      if (tag_m[s][TW-1]) begin
         for (int b = 0; b < LB; b++) begin
            d = {$urandom, $urandom};
            t = {1'b1, 12'($urandom)};
            set_side(s, 1'b1, d, t);
            w = $urandom_range(0, 2);
            for (int k = 0; k <= w; k++) begin
               bus_reqack  = (k == w);
               bus_respcyc = 1'($urandom);
               set_respack(s, 1'($urandom));
               #1;
               chk("wr_owner", owner, own);
               chk("wr_data", bus_req, d);
               chk("wr_tag", bus_reqtag, t);
               chk("wr_ack", ack_of(s), k == w);
               chk("wr_other_ack", ack_of(o), 1'b0);
               chk("wr_respcyc", respcyc_of(s), 1'b0);
               chk("wr_respack", bus_respack, 1'b0);
               adv();
            end
         end
         set_side(s, 1'b0, '0, '0);
      end else begin
         set_side(s, 1'b0, '0, '0);
         for (int b = 0; b < LB; b++) begin
            w = $urandom_range(0, 2);
            for (int k = 0; k <= w; k++) begin
               hs = (k == w);
               bus_respcyc = hs | 1'($urandom);
               bus_resp    = {$urandom, $urandom};
               bus_resptag = 13'($urandom);
               set_respack(s, hs);
               set_respack(o, 1'($urandom));
               if (b == rst_beat && hs) begin
                  reset = 1;
                  #1;
                  chk("rst_owner", owner, 2'b00);
                  chk("rst_respcyc", respcyc_of(s), 1'b0);
                  chk("rst_resp", resp_of(s), '0);
                  chk("rst_respack", bus_respack, 1'b0);
                  chk("rst_buscyc", bus_reqcyc, 1'b0);
                  adv();
                  reset = 0;
                  clear_all();
                  return;
               end
               #1;
               chk("rd_owner", owner, own);
               chk("rd_cyc", respcyc_of(s), bus_respcyc);
               chk("rd_data", resp_of(s), bus_resp);
               chk("rd_tag", resptag_of(s), bus_resptag);
               chk("rd_other_cyc", respcyc_of(o), 1'b0);
               chk("rd_other_ack", ack_of(o), 1'b0);
               chk("rd_respack", bus_respack, hs);
               adv();
            end
         end
      end
      bus_reqack = 0;
      bus_respcyc = 0;
      ibus_respack = 0;
      dbus_respack = 0;
   endtask

   initial begin
      int s;
      reset = 1;
      clear_all();
      pend[0] = 0;
      pend[1] = 0;
      last_tb = 1;
      ibus_reqcyc = 1;
      @(negedge clk);
      #1;
      chk("reset_owner", owner, 2'b00);
      chk("reset_buscyc", bus_reqcyc, 1'b0);
      chk("reset_iack", ibus_reqack, 1'b0);
      chk("reset_respack", bus_respack, 1'b0);
      chk("reset_busreq", bus_req, '0);
      adv();
      reset = 0;
      clear_all();

      bus_respcyc = 1;
      ibus_respack = 1;
      dbus_respack = 1;
      bus_resp = {$urandom, $urandom};
      #1;
      chk("idle_resp_i", ibus_respcyc, 1'b0);
      chk("idle_resp_d", dbus_respcyc, 1'b0);
      chk("idle_respack", bus_respack, 1'b0);
      adv();
      clear_all();

      post(0, 0);
      post(1, 0);
      s = pick();
      serve(s, -1);
      s = pick();
      serve(s, -1);

      post(1, 1);
      s = pick();
      serve(s, -1);

      post(0, 0);
      post(1, 0);
      s = pick();
      #1;
      chk("abort_idle_owner", owner, 2'b00);
      adv();
      ibus_reqcyc = 0;
      bus_reqack = 0;
      #1;
      chk("abort_owner", owner, (s == 0) ? 2'b01 : 2'b10);
      chk("abort_buscyc", bus_reqcyc, 1'b0);
      chk("abort_iack", ibus_reqack, 1'b0);
      adv();
      s = pick();
      serve(s, -1);

      post(0, 0);
      s = pick();
      serve(s, 3);
      last_tb = 1;
      pend[0] = 0;
      pend[1] = 0;
      post(0, 0);
      s = pick();
      serve(s, -1);

      for (int n = 0; n < 25; n++) begin
         if (!pend[0] && $urandom_range(0, 1) == 1) post(0, 0);
         if (!pend[1] && $urandom_range(0, 1) == 1) post(1, 1'($urandom));
         if (!pend[0] && !pend[1]) post(0, 0);
         s = pick();
         serve(s, -1);
      end
      while (pend[0] || pend[1]) begin
         s = pick();
         serve(s, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/membus_scheduler.md
MEMBUS_SCHEDULER -- requirements
Module: membus_scheduler

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, meaning the width of every bus data/request word.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, meaning the width of every tag; bit [BUS_TAG_WIDTH-1] = 1 marks a write.
REQ-003 SHALL have parameter LINE_BEATS, default 8, meaning beats per 512-bit line transfer.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- ibus_reqcyc / ibus_req / ibus_reqtag  in  1/DATA/TAG  fetcher request (read only).
- ibus_reqack  out  1  request beat accepted.
- ibus_respcyc / ibus_resp / ibus_resptag  out  1/DATA/TAG  response to fetcher.
- ibus_respack  in  1  fetcher consumed response beat.
- dbus_reqcyc / dbus_req / dbus_reqtag  in  1/DATA/TAG  data-memory request (read or write).
- dbus_reqack  out  1  request beat accepted.
- dbus_respcyc / dbus_resp / dbus_resptag  out  1/DATA/TAG  response to data memory.
- dbus_respack  in  1  data memory consumed response beat.
- bus_reqcyc / bus_req / bus_reqtag  out  1/DATA/TAG  shared system bus request.
- bus_reqack  in  1  bus accepted request beat.
- bus_respcyc / bus_resp / bus_resptag  in  1/DATA/TAG  bus response.
- bus_respack  out  1  response beat consumed.
- owner  out  2  00 none, 01 I-side, 10 D-side (debug/status).

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, WDATA, RESP; one transaction outstanding at a time.
REQ-006 In IDLE, SHALL grant on any reqcyc; if both request in the same cycle, SHALL grant the requester not granted last (round robin); grant takes effect next cycle (ADDR).
REQ-007 In ADDR/WDATA, SHALL drive bus_reqcyc/req/reqtag combinationally from the owner only; bus_reqack SHALL route to the owner's reqack only; the non-owner's reqack SHALL be 0.
REQ-008 On the ADDR beat accepted (reqcyc && reqack): tag MSB=1 -> WDATA with beat counter 0; else -> RESP with counter 0.
REQ-009 In WDATA, each accepted beat SHALL increment a counter; the LINE_BEATS-th accepted beat -> IDLE (write completes without response phase).
REQ-010 In RESP, bus_respcyc/resp/resptag SHALL route to the owner only; bus_respack = owner's respack; non-owner respcyc SHALL be 0.
REQ-011 In RESP, each beat with bus_respcyc && bus_respack SHALL increment the counter; the LINE_BEATS-th beat -> IDLE.
REQ-012 Counter width SHALL be clog2(LINE_BEATS)+1 bits; no wrap occurs within a transaction.
REQ-013 If the owner deasserts reqcyc in ADDR or WDATA before acceptance, SHALL abort to IDLE the next cycle without counting.
REQ-014 bus_respcyc outside RESP SHALL be ignored: not forwarded, bus_respack = 0.
REQ-015 Last-granted pointer SHALL update only on grant; a requester waits at most one full transaction of the other side.
REQ-016 A request arriving during RESP or WDATA SHALL see reqack = 0 until granted.
REQ-017 Back-to-back: IDLE re-arbitration occurs the cycle after completion; no zero-cycle grant.

Reset
REQ-018 On reset, SHALL asynchronously enter IDLE, clear counter, set owner = 00, set last-granted = D-side (first tie goes to I-side).
REQ-019 During reset, all reqcyc, reqack, respcyc and respack outputs SHALL be 0; data/tag outputs 0.
REQ-020 Reset mid-transaction SHALL drop the transaction; no beat is forwarded after reset asserts.

Structure
REQ-021 State enum, owner encoding and the write-tag bit position SHALL live in a shared package (membus_pkg) also used by fetcher and datamemory.
REQ-022 Round-robin choice SHALL be a sub-module rr_arb2 (2 requests, last-grant input, grant output, combinational).

Verification
REQ-023 I read alone: ibus_reqcyc, tag MSB 0 -> bus_reqcyc next cycle, ack routed to I, 8 response beats reach ibus only, owner 01 -> 00 after beat 8.
REQ-024 Simultaneous I and D requests after reset -> I granted first, D granted the cycle after I's 8th response beat.
REQ-025 D write, tag MSB 1 -> address + 8 data beats forwarded, IDLE after 8th acked data beat, no respcyc to dbus.
REQ-026 bus_respcyc asserted in IDLE -> ibus/dbus_respcyc = 0, bus_respack = 0.
REQ-027 Reset asserted at response beat 4 -> outputs 0 in the same cycle, IDLE; new I request served normally.
REQ-028 Owner drops reqcyc in ADDR before ack -> IDLE next cycle; the pending other-side request is granted.
